// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking gate scheduler: gate FSM states,
// default gate timings and round-robin lane selection.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECIDE = 3'd1,
    OPEN   = 3'd2,
    COUNT  = 3'd3,
    CLOSE  = 3'd4
  } gate_state_e;

  localparam int unsigned DEF_OPEN_CYCLES  = 16;
  localparam int unsigned DEF_CLOSE_CYCLES = 4;
  localparam int unsigned MAX_LANES        = 8;

  // Lane after `lane`, wrapping at n.
  function automatic logic [2:0] rr_next(input logic [2:0] lane, input int unsigned n);
    if (32'(lane) + 32'd1 >= n) return 3'd0;
    return lane + 3'd1;
  endfunction

  // First requesting lane at or after ptr (wrapping); the smallest offset wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = ptr;
    for (int unsigned k = MAX_LANES; k > 0; k--) begin
      idx = 3'((32'(ptr) + k - 32'd1) % n);
      if (k <= n && req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/parking_gate_scheduler_gate_channel.sv
// One side of the car park: round-robin lane arbiter, gate FSM and gate timer.
module gate_channel
  import parking_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned CHECK_SPACE  = 1,
  parameter int unsigned OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] is_uni,
  input  logic [N-1:0] passed,
  input  logic         space_uni,
  input  logic         space_any,
  output logic [N-1:0] gate_open,
  output logic [N-1:0] deny,
  output logic         count_pulse,
  output logic         count_uni,
  output logic         busy
);

  localparam int unsigned LW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TMAX = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  gate_state_e   state_q, state_d;
  logic [LW-1:0] lane_q, lane_d, ptr_q, ptr_d, pick;
  logic          uni_q, uni_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [N-1:0]  gate_d, deny_d;
  logic          count_d, count_uni_d, busy_d;
  logic          space_ok;

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      ptr_q       <= '0;
      uni_q       <= 1'b0;
      timer_q     <= '0;
      gate_open   <= '0;
      deny        <= '0;
      count_pulse <= 1'b0;
      count_uni   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      ptr_q       <= ptr_d;
      uni_q       <= uni_d;
      timer_q     <= timer_d;
      gate_open   <= gate_d;
      deny        <= deny_d;
      count_pulse <= count_d;
      count_uni   <= count_uni_d;
      busy        <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    ptr_d       = ptr_q;
    uni_d       = uni_q;
    timer_d     = (timer_q == TW'(TMAX - 1)) ? timer_q : timer_q + TW'(1);
    gate_d      = '0;
    deny_d      = '0;
    count_d     = 1'b0;
    count_uni_d = 1'b0;
    busy_d      = (state_q != IDLE);
    pick        = LW'(rr_pick(8'(req), 3'(ptr_q), N));
    space_ok    = (CHECK_SPACE == 0) || (uni_q ? space_uni : space_any);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (|req) begin
          lane_d  = pick;
          uni_d   = is_uni[pick];
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        timer_d = '0;
        if (space_ok) begin
          state_d = OPEN;
        end else begin
          deny_d[lane_q] = 1'b1;
          state_d        = CLOSE;
        end
      end
      OPEN: begin
        gate_d[lane_q] = 1'b1;
        // A pass in the expiry cycle still counts the car.
        if (passed[lane_q]) begin
          state_d = COUNT;
          timer_d = '0;
        end else if (timer_q == TW'(OPEN_CYCLES - 1)) begin
          deny_d[lane_q] = 1'b1;
          state_d        = CLOSE;
          timer_d        = '0;
        end
      end
      COUNT: begin
        count_d     = 1'b1;
        count_uni_d = uni_q;
        state_d     = CLOSE;
        timer_d     = '0;
      end
      CLOSE: begin
        if (timer_q == TW'(CLOSE_CYCLES - 1)) begin
          ptr_d   = LW'(rr_next(3'(lane_q), N));
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Entry/exit barrier sequencer in front of the occupancy counter: one gate
// channel per side, entry gated on the counter's space flags.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int unsigned NUM_ENTRY    = 4,
  parameter int unsigned NUM_EXIT     = 2,
  parameter int unsigned OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_ENTRY-1:0] ent_req,
  input  logic [NUM_ENTRY-1:0] ent_is_uni,
  input  logic [NUM_ENTRY-1:0] ent_passed,
  input  logic [NUM_EXIT-1:0]  ext_req,
  input  logic [NUM_EXIT-1:0]  ext_is_uni,
  input  logic [NUM_EXIT-1:0]  ext_passed,
  input  logic                 uni_is_vacated_space,
  input  logic                 is_vacated_space,
  output logic [NUM_ENTRY-1:0] ent_gate_open,
  output logic [NUM_ENTRY-1:0] ent_deny,
  output logic [NUM_EXIT-1:0]  ext_gate_open,
  output logic [NUM_EXIT-1:0]  ext_deny,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic                 ent_busy,
  output logic                 ext_busy
);

  gate_channel #(
    .N(NUM_ENTRY), .CHECK_SPACE(1), .OPEN_CYCLES(OPEN_CYCLES), .CLOSE_CYCLES(CLOSE_CYCLES)
  ) u_entry (
    .clk(clk), .rst_n(rst_n),
    .req(ent_req), .is_uni(ent_is_uni), .passed(ent_passed),
    .space_uni(uni_is_vacated_space), .space_any(is_vacated_space),
    .gate_open(ent_gate_open), .deny(ent_deny),
    .count_pulse(car_entered), .count_uni(is_uni_car_entered), .busy(ent_busy)
  );

  // Leaving never needs space in the car park.
  gate_channel #(
    .N(NUM_EXIT), .CHECK_SPACE(0), .OPEN_CYCLES(OPEN_CYCLES), .CLOSE_CYCLES(CLOSE_CYCLES)
  ) u_exit (
    .clk(clk), .rst_n(rst_n),
    .req(ext_req), .is_uni(ext_is_uni), .passed(ext_passed),
    .space_uni(1'b1), .space_any(1'b1),
    .gate_open(ext_gate_open), .deny(ext_deny),
    .count_pulse(car_exited), .count_uni(is_uni_car_exited), .busy(ext_busy)
  );

endmodule

// File: doc/parking_gate_scheduler.md
Name: parking_gate_scheduler

Overview:
Sequences the barrier gates that feed the parking occupancy counter. It arbitrates NUM_ENTRY entry lanes and NUM_EXIT exit lanes round-robin, one active car per side. Before opening an entry gate it checks the counter's space flags. It emits exactly one car_entered / car_exited pulse per car that physically clears a loop sensor. It sits between the lane hardware (request buttons, loop sensors, barrier drivers) and the occupancy counter.

Parameters:
NUM_ENTRY, 4, number of entry lanes (1..8)
NUM_EXIT, 2, number of exit lanes (1..8)
OPEN_CYCLES, 16, maximum cycles a gate stays open waiting for its pass sensor
CLOSE_CYCLES, 4, cycles the gate is held closed before the side accepts a new request

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ent_req  in  NUM_ENTRY  car waiting at entry lane i (level)
ent_is_uni  in  NUM_ENTRY  waiting car is a university car
ent_passed  in  NUM_ENTRY  entry loop sensor: car cleared barrier (level)
ext_req  in  NUM_EXIT  car waiting at exit lane j
ext_is_uni  in  NUM_EXIT  exiting car is a university car
ext_passed  in  NUM_EXIT  exit loop sensor
uni_is_vacated_space  in  1  from counter
is_vacated_space  in  1  from counter
ent_gate_open  out  NUM_ENTRY  barrier drive, one-hot or zero
ent_deny  out  NUM_ENTRY  one-cycle pulse: refused for no space, or timed out
ext_gate_open  out  NUM_EXIT  barrier drive
ext_deny  out  NUM_EXIT  one-cycle pulse: timed out
car_entered  out  1  one-cycle pulse to counter
is_uni_car_entered  out  1  valid with car_entered, else 0
car_exited  out  1  one-cycle pulse to counter
is_uni_car_exited  out  1  valid with car_exited, else 0
ent_busy  out  1  entry side not IDLE
ext_busy  out  1  exit side not IDLE

Behaviour:
- Reset, asynchronous and at any point mid-operation: every output 0; both FSMs IDLE; round-robin pointers 0; timers 0. All gates close immediately.
- All outputs are registered. The entry and exit sides are independent FSMs with identical structure.
- State IDLE: if any req bit is set, grant the first requesting lane at or after the pointer (wrapping). Latch the lane index and its is_uni bit, then go to DECIDE. Requests that arrive later are not latched.
- State DECIDE, one cycle:
  - Entry side: the required flag is uni_is_vacated_space if the latched is_uni bit is 1, else is_vacated_space.
  - Flag 1: go to OPEN.
  - Flag 0: pulse deny[lane] for one cycle, go to CLOSE.
  - Exit side always goes to OPEN.
- State OPEN: gate_open[lane]=1. The timer counts from 0.
  - passed[lane]=1: go to COUNT.
  - Otherwise, if timer==OPEN_CYCLES-1: pulse deny[lane], go to CLOSE.
  - passed and timer expiry in the same cycle: passed wins.
  - passed on non-granted lanes is ignored. Dropping req has no effect.
- State COUNT, one cycle: gate_open=0. car_entered (car_exited) =1 and is_uni_* = the latched bit. Go to CLOSE.
- State CLOSE: CLOSE_CYCLES cycles with gate closed. Then pointer = lane+1 mod N, go to IDLE.
- Latency: req sampled at edge k gives gate_open high from edge k+2. passed sampled at edge m gives the count pulse during cycle m+1.
- Entry and exit count pulses may coincide in the same cycle; both are asserted.
- The latched is_uni bit is immune to later changes on the ent_is_uni / ext_is_uni inputs.
- Timer width is clog2(OPEN_CYCLES) bits, sized to cover CLOSE_CYCLES as well. It saturates and never wraps.

Decomposition:
- Package parking_pkg holds:
  - the state enum {IDLE, DECIDE, OPEN, COUNT, CLOSE};
  - default OPEN_CYCLES and CLOSE_CYCLES constants;
  - a round-robin next-index function.
- Sub-module gate_channel contains one FSM, the arbiter and the timer. It has parameters N and CHECK_SPACE and is instantiated twice: entry with CHECK_SPACE=1, exit with CHECK_SPACE=0 and space tied to 1.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Assert rst_n=0 while ent_gate_open[2]=1 -> gate drops the same cycle with no count pulse. After release, ent_req=0001 -> lane 0 is served.
- Uni entry: ent_req[0]=1, ent_is_uni[0]=1, uni_is_vacated_space=1 -> ent_gate_open=0001 two cycles later. Assert ent_passed[0] after 5 cycles -> car_entered=1 and is_uni_car_entered=1 for exactly one cycle. ent_busy clears CLOSE_CYCLES+1 cycles later.
- No space: ent_req[1]=1, ent_is_uni[1]=0, is_vacated_space=0 -> single ent_deny[1] pulse; no gate_open; no car_entered.
- Round robin: ent_req=1101 held, each served car passes -> service order lanes 0, 2, 3, 0.
- Timeout: exit lane 1 opens and ext_passed stays 0 -> gate open exactly 16 cycles, ext_deny[1] pulses, car_exited never asserted.
- Simultaneous: entry and exit passed sensors asserted on the same edge -> car_entered and car_exited both 1 in the same cycle, each with its latched is_uni.
